regfile_dump_reader: RTL
========================

Name: regfile_dump_reader

Overview:
- Read-side sequencer for the 32 x 64 register file.
- On a start request, drives the A-port address (AA) and enable (EN_A) across a programmable register range.
- Captures each A word and streams it out on a valid/ready interface, for debug dump, context save and testbench scoreboarding.
- Never drives WR, DA or D. The write port stays owned by the datapath.

Parameters:
- N, 32, number of registers
- M, 64, register width in bits
- AW, 5, address width; must equal log2(N)

Ports:
- clock  in  1  rising-edge clock shared with the register file
- reset  in  1  synchronous, active-high reset
- start  in  1  request a dump; sampled only in IDLE
- first_reg  in  AW  first register index of the dump
- last_reg  in  AW  last register index of the dump (inclusive)
- AA  out  AW  A-port address to the register file
- EN_A  out  1  A-port enable to the register file
- A  in  M  A-port data from the register file (combinational from AA)
- out_data  out  M  captured register word
- out_idx  out  AW  index of the word in out_data
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  consumer accepts the beat
- out_last  out  1  final beat of the dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse when the dump completes

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset has priority over every other input in every state.
- Reset mid-dump aborts the dump: no done pulse, no further beats.
- States: IDLE, ADDR, SEND, DONE (plus SUM when the optional feature is compiled in).
- IDLE:
  - on start=1, latch first_reg/last_reg, set AA<=first_reg and EN_A<=1, assert busy, go to ADDR.
  - start in any other state is ignored.
- ADDR: one cycle. On the edge, out_data<=A, out_idx<=AA, out_valid<=1, out_last<=(AA==last latched), go to SEND.
- SEND:
  - hold out_data, out_idx and out_last stable while out_valid=1 and out_ready=0.
  - on handshake (out_valid & out_ready) with AA!=last: out_valid<=0, AA<=AA+1 mod N (wraps 31 to 0), go to ADDR.
  - on handshake with AA==last: out_valid<=0, EN_A<=0, go to DONE.
- DONE: done=1 for exactly one cycle, busy<=0, return to IDLE. A start in the DONE cycle is ignored.
- Range is walked upward with wrap-around.
  - beat count = ((last_reg - first_reg) mod N) + 1.
  - first_reg == last_reg gives exactly one beat.
- Latency and throughput:
  - start accepted at edge t; first out_valid at edge t+2.
  - with out_ready=1, one beat per 2 cycles.
  - done is high in the cycle after the final handshake.
- EN_A is 1 in ADDR and SEND, and 0 in IDLE and DONE.
- Coherency: each word is the value on A at its ADDR-state capture edge. Datapath writes to a register after it has been captured do not affect the stream.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- With the macro defined:
  - an M-bit XOR accumulator clears on start and folds in each captured word.
  - after the final register handshake, go to SUM instead of DONE.
  - SUM presents one extra beat: out_data=accumulator, out_idx=0, out_last=1, held until handshake, then go to DONE.
  - out_last is 0 on all register beats.
- Without the macro: no accumulator and no SUM state; out_last marks the final register beat.

Decomposition:
- Shared package regfile_pkg holds:
  - constants N, M, AW
  - the dump state enum (IDLE, ADDR, SEND, DONE, SUM)
- One sub-module is natural: regfile_dump_out_reg.
  - holds out_data/out_idx/out_last/out_valid.
  - load and hold/clear controls come from the FSM.

Test Plan:
- Full dump, ready always 1: preload R[i]=i*64'h0101010101010101, start with first=0, last=31.
  - 32 beats, idx 0..31, data matching the preload.
  - first valid at cycle 2, final beat at cycle 64, out_last only on idx 31, done pulse at cycle 65.
- Backpressure: hold out_ready=0 for 5 cycles on beat idx 3.
  - out_data/out_idx stay stable and no beat is lost or duplicated.
  - AA stays 3 throughout.
- Wrap-around: first=30, last=1.
  - exactly 4 beats with idx 30, 31, 0, 1.
  - out_last on idx 1.
- Single and ignored start: first=last=7 gives one beat, idx 7, out_last=1.
  - a start pulsed during SEND produces no extra dump.
- Reset mid-dump: assert reset during the third beat's SEND.
  - next cycle all outputs 0, no done pulse.
  - a subsequent start works normally.
- Checksum (REGFILE_DUMP_CHECKSUM_EN): dump 0..3 with values 1, 2, 4, 8.
  - 5 beats; the last has data 64'hF, idx 0, out_last=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and dump-sequencer state encoding for the 32 x 64 register file.
package regfile_pkg;

    localparam int N  = 32;
    localparam int M  = 64;
    localparam int AW = 5;

    typedef logic [2:0] dump_state_t;

    localparam dump_state_t ST_IDLE = 3'd0;
    localparam dump_state_t ST_ADDR = 3'd1;
    localparam dump_state_t ST_SEND = 3'd2;
    localparam dump_state_t ST_DONE = 3'd3;
    localparam dump_state_t ST_SUM  = 3'd4;

    // Register indices walk upward and wrap from N-1 back to 0.
    function automatic logic [AW-1:0] next_index(input logic [AW-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_dump_out_reg.sv
// Output beat register for the dump reader: holds one word, its index and the last flag.
module regfile_dump_out_reg
    import regfile_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          clear,
    input  logic [M-1:0]  load_data,
    input  logic [AW-1:0] load_idx,
    input  logic          load_last,
    output logic [M-1:0]  out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_last,
    output logic          out_valid
);

    logic [M-1:0]  data_q,  data_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic          last_q,  last_d;
    logic          valid_q, valid_d;

    // A load always wins over a clear so a new beat can follow a handshake back to back.
    always_comb begin
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            idx_d   = load_idx;
            last_d  = load_last;
            valid_d = 1'b1;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side dump sequencer: walks the A port over a register range and streams each word out.
// Optional XOR checksum trailer beat is compiled in with REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader
    import regfile_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] first_reg,
    input  logic [AW-1:0] last_reg,
    output logic [AW-1:0] AA,
    output logic          EN_A,
    input  logic [M-1:0]  A,
    output logic [M-1:0]  out_data,
    output logic [AW-1:0] out_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    dump_state_t   state_q, state_d;
    logic [AW-1:0] aa_q,    aa_d;
    logic [AW-1:0] last_q,  last_d;
    logic          en_a_q,  en_a_d;
    logic          busy_q,  busy_d;
    logic          done_q,  done_d;

    logic          beat_load;
    logic          beat_clear;
    logic [M-1:0]  beat_data;
    logic [AW-1:0] beat_idx;
    logic          beat_last;
    logic          handshake;
    logic          at_last;

`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [M-1:0]  acc_q, acc_d;
`endif

    assign handshake = out_valid & out_ready;
    assign at_last   = (aa_q == last_q);

    always_comb begin
        state_d    = state_q;
        aa_d       = aa_q;
        last_d     = last_q;
        en_a_d     = en_a_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        beat_load  = 1'b0;
        beat_clear = 1'b0;
        beat_data  = A;
        beat_idx   = aa_q;
        beat_last  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        acc_d      = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    aa_d    = first_reg;
                    last_d  = last_reg;
                    en_a_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_ADDR;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            ST_ADDR: begin
                // The word is captured here, so later writes to this register cannot leak in.
                beat_load = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                beat_last = 1'b0;
                acc_d     = acc_q ^ A;
`else
                beat_last = at_last;
`endif
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    if (!at_last) begin
                        beat_clear = 1'b1;
                        aa_d       = next_index(aa_q);
                        state_d    = ST_ADDR;
                    end else begin
                        en_a_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                        // Trailer beat replaces the final register beat without a gap cycle.
                        beat_load = 1'b1;
                        beat_data = acc_q;
                        beat_idx  = '0;
                        beat_last = 1'b1;
                        state_d   = ST_SUM;
`else
                        beat_clear = 1'b1;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
`endif
                    end
                end
            end
            ST_SUM: begin
                if (handshake) begin
                    beat_clear = 1'b1;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                en_a_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            aa_q    <= '0;
            last_q  <= '0;
            en_a_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            aa_q    <= aa_d;
            last_q  <= last_d;
            en_a_q  <= en_a_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef REGFILE_DUMP_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    regfile_dump_out_reg u_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (beat_load),
        .clear     (beat_clear),
        .load_data (beat_data),
        .load_idx  (beat_idx),
        .load_last (beat_last),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_valid (out_valid)
    );

    assign AA   = aa_q;
    assign EN_A = en_a_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
